// File: rtl/mem_port_arbiter_if.sv
// Signal bundle around mem_port_arbiter: fetch port, load/store port and memory port.
// ls_misalign exists only when MISALIGN_TRAP_EN is defined.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [31:0]       if_rdata;
  logic              ls_req;
  logic [ADDR_W-1:0] ls_addr;
  logic [1:0]        ls_size;
  logic [31:0]       ls_wdata;
  logic              ls_done;
  logic [31:0]       ls_rdata;
  logic              stall;
  logic              bus_err;
`ifdef MISALIGN_TRAP_EN
  logic              ls_misalign;
`endif
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  // master is the arbiter; slave is the pipeline plus memory surrounding it
  modport master (
    input  if_req, if_addr, ls_req, ls_addr, ls_size, ls_wdata, mem_ack, mem_rdata,
    output if_valid, if_rdata, ls_done, ls_rdata, stall, bus_err,
`ifdef MISALIGN_TRAP_EN
    output ls_misalign,
`endif
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output if_req, if_addr, ls_req, ls_addr, ls_size, ls_wdata, mem_ack, mem_rdata,
    input  if_valid, if_rdata, ls_done, ls_rdata, stall, bus_err,
`ifdef MISALIGN_TRAP_EN
    input  ls_misalign,
`endif
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, load/store first.
// Define MISALIGN_TRAP_EN to trap misaligned half/word stores instead of issuing them.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                RST,
  mem_port_arbiter_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(32'd3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc_s;
  logic               timeout_s, misalign_s, ls_we_s;
  logic [3:0]         ls_be_s;
  logic [31:0]        ls_wdata_s;

  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               if_valid_q, if_valid_d, ls_done_q, ls_done_d, bus_err_q, bus_err_d;
  logic [31:0]        if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
`ifdef MISALIGN_TRAP_EN
  logic               ls_misalign_q, ls_misalign_d;

  assign misalign_s = ((bus.ls_size == 2'b01) & bus.ls_addr[0]) |
                      ((bus.ls_size == 2'b10) & (|bus.ls_addr[1:0]));
`else
  assign misalign_s = 1'b0;
`endif

  // An ack in the limit cycle suppresses the timeout
  assign cnt_inc_s = cnt_q + CNT_W'(1);
  assign timeout_s = (TIMEOUT != 0) && (cnt_inc_s == CNT_W'(TIMEOUT)) && !bus.mem_ack;

  // Byte-lane placement of the pending load/store request
  always_comb begin
    ls_be_s    = 4'b1111;
    ls_wdata_s = 32'd0;
    ls_we_s    = 1'b0;
    case (bus.ls_size)
      2'b00: begin
        ls_be_s    = 4'b0001 << bus.ls_addr[1:0];
        ls_wdata_s = {4{bus.ls_wdata[7:0]}};
        ls_we_s    = 1'b1;
      end
      2'b01: begin
        ls_be_s    = 4'b0011 << {bus.ls_addr[1], 1'b0};
        ls_wdata_s = {2{bus.ls_wdata[15:0]}};
        ls_we_s    = 1'b1;
      end
      2'b10: begin
        ls_be_s    = 4'b1111;
        ls_wdata_s = bus.ls_wdata;
        ls_we_s    = 1'b1;
      end
      default: begin
        ls_be_s    = 4'b1111;
        ls_wdata_s = 32'd0;
        ls_we_s    = 1'b0;
      end
    endcase
  end

  // State and timeout counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and timeout counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (bus.ls_req) begin
          state_d = misalign_s ? RESP : DATA;
        end else if (bus.if_req) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH, DATA: begin
        if (bus.mem_ack || timeout_s) begin
          state_d = RESP;
        end else begin
          state_d = state_q;
        end
        cnt_d = bus.mem_ack ? cnt_q : cnt_inc_s;
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Registered outputs are computed from the transition about to happen
  always_comb begin
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = {ADDR_W{1'b0}};
    mem_be_d    = 4'b0000;
    mem_wdata_d = 32'd0;
    if_valid_d  = 1'b0;
    ls_done_d   = 1'b0;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
`ifdef MISALIGN_TRAP_EN
    ls_misalign_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (state_d == DATA) begin
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we_s;
          mem_addr_d  = bus.ls_addr & WORD_MASK;
          mem_be_d    = ls_be_s;
          mem_wdata_d = ls_wdata_s;
        end else if (state_d == FETCH) begin
          mem_req_d   = 1'b1;
          mem_addr_d  = bus.if_addr & WORD_MASK;
          mem_be_d    = 4'b1111;
        end else if (state_d == RESP) begin
          ls_done_d  = 1'b1;
          ls_rdata_d = 32'd0;
`ifdef MISALIGN_TRAP_EN
          ls_misalign_d = 1'b1;
`endif
        end else begin
          mem_req_d = 1'b0;
        end
      end
      FETCH, DATA: begin
        if (state_d == RESP) begin
          bus_err_d = timeout_s;
          if (state_q == FETCH) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_ack ? bus.mem_rdata : 32'd0;
          end else begin
            ls_done_d  = 1'b1;
            ls_rdata_d = bus.mem_ack ? bus.mem_rdata : 32'd0;
          end
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = mem_we_q;
          mem_addr_d  = mem_addr_q;
          mem_be_d    = mem_be_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'd0;
      if_valid_q  <= 1'b0;
      ls_done_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      ls_rdata_q  <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      ls_misalign_q <= 1'b0;
`endif
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      ls_done_q   <= ls_done_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
`ifdef MISALIGN_TRAP_EN
      ls_misalign_q <= ls_misalign_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_done   = ls_done_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.stall     = bus.ls_req & ~ls_done_q;
`ifdef MISALIGN_TRAP_EN
  assign bus.ls_misalign = ls_misalign_q;
`endif

endmodule
